// File: rtl/seg7_capture_if.sv
// Segment capture bus: the sampled segment input plus the valid/ready result port.
// The master modport is the capture block. The slave modport is the side that drives segments and consumes results.
interface seg7_capture_if;
  logic [6:0] iSEG;
  logic       iSEG_EN;
  logic [3:0] oDIG;
  logic       oERR;
  logic       oVALID;
  logic       iREADY;
  logic       oDROP;

  modport master (
    input  iSEG, iSEG_EN, iREADY,
    output oDIG, oERR, oVALID, oDROP
  );

  modport slave (
    output iSEG, iSEG_EN, iREADY,
    input  oDIG, oERR, oVALID, oDROP
  );
endinterface

// File: rtl/seg7_capture.sv
// Qualifies an active-low 7-segment pattern as stable over STABLE_CYCLES enabled samples.
// Each new stable glyph is decoded to hex and offered once on a registered valid/ready slot.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  seg7_capture_if.master bus
);

  localparam logic [7:0] STABLE   = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLEM1 = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] BLANK    = 7'b1111111;

  // Returns {illegal, digit}. An illegal pattern reports digit 0.
  function automatic logic [4:0] decodeGlyph(input logic [6:0] seg);
    logic [4:0] res;
    case (seg)
      7'b1000000: res = {1'b0, 4'h0};
      7'b1111001: res = {1'b0, 4'h1};
      7'b0100100: res = {1'b0, 4'h2};
      7'b0110000: res = {1'b0, 4'h3};
      7'b0011001: res = {1'b0, 4'h4};
      7'b0010010: res = {1'b0, 4'h5};
      7'b0000010: res = {1'b0, 4'h6};
      7'b1111000: res = {1'b0, 4'h7};
      7'b0000000: res = {1'b0, 4'h8};
      7'b0011000: res = {1'b0, 4'h9};
      7'b0001000: res = {1'b0, 4'hA};
      7'b0000011: res = {1'b0, 4'hB};
      7'b1000110: res = {1'b0, 4'hC};
      7'b0100001: res = {1'b0, 4'hD};
      7'b0000110: res = {1'b0, 4'hE};
      7'b0001110: res = {1'b0, 4'hF};
      default:    res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  logic [6:0] cand;
  logic [7:0] cnt;
  logic [6:0] last;
  logic [3:0] digReg;
  logic       errReg;
  logic       validReg;
  logic       dropReg;

  logic       sampleSame;
  logic       qualify;
  logic       newResult;
  logic       slotFree;
  logic       load;
  logic       drop;
  logic [4:0] decoded;

  always_comb begin
    sampleSame = 1'b0;
    qualify    = 1'b0;
    newResult  = 1'b0;
    slotFree   = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    decoded    = decodeGlyph(cand);

    sampleSame = bus.iSEG_EN && (bus.iSEG == cand);
    // Qualify fires only on the sample that completes the run, so a saturated count never re-fires.
    qualify    = sampleSame && (cnt == STABLEM1);
    newResult  = qualify && (cand != last) && (cand != BLANK);
    slotFree   = !validReg || bus.iREADY;
    load       = newResult && slotFree;
    drop       = newResult && !slotFree;
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      cand <= BLANK;
      cnt  <= STABLE;
      last <= BLANK;
    end else begin
      if (bus.iSEG_EN) begin
        if (bus.iSEG != cand) begin
          cand <= bus.iSEG;
          cnt  <= 8'd1;
        end else if (cnt < STABLE) begin
          cnt <= cnt + 8'd1;
        end
      end
      if (qualify) begin
        last <= cand;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      digReg   <= '0;
      errReg   <= 1'b0;
      validReg <= 1'b0;
      dropReg  <= 1'b0;
    end else begin
      dropReg <= drop;
      if (load) begin
        digReg   <= decoded[3:0];
        errReg   <= decoded[4];
        validReg <= 1'b1;
      end else if (validReg && bus.iREADY) begin
        validReg <= 1'b0;
      end
    end
  end

  assign bus.oDIG   = digReg;
  assign bus.oERR   = errReg;
  assign bus.oVALID = validReg;
  assign bus.oDROP  = dropReg;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with STABLE_CYCLES=4.
// Each scenario task drives segment vectors and checks hand-computed results one edge at a time.
module tb_seg7_capture;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BAD   = 7'b1010101;

  logic clk;
  logic rstN;
  seg7_capture_if bus ();

  seg7_capture #(.STABLE_CYCLES(4)) dut (
    .iCLK   (clk),
    .iRST_N (rstN),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Records every accepted transfer (oVALID && iREADY at a rising edge outside reset).
  int       xfers = 0;
  logic [3:0] xferDig = '0;
  logic       xferErr = 1'b0;

  always @(posedge clk) begin
    if (rstN && bus.oVALID && bus.iREADY) begin
      xfers   <= xfers + 1;
      xferDig <= bus.oDIG;
      xferErr <= bus.oERR;
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one input vector across a rising edge and settle past it.
  task automatic drive(input logic [6:0] seg, input logic en, input logic rdy);
    bus.iSEG    = seg;
    bus.iSEG_EN = en;
    bus.iREADY  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstN = 1'b0;
    drive(SEG_3, 1'b1, 1'b1);
    drive(SEG_3, 1'b1, 1'b1);
    rstN = 1'b1;
    total++;
    if ({bus.oVALID, bus.oERR, bus.oDROP, bus.oDIG} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b e=%b d=%b dig=%h want all 0",
               bus.oVALID, bus.oERR, bus.oDROP, bus.oDIG);
    end
    for (int i = 0; i < 6; i++) drive(SEG_BLANK, 1'b1, 1'b1);
    total++;
    if (xfers !== 0 || bus.oVALID !== 1'b0) begin
      bad++;
      $display("FAIL reset_blank_no_emit got xfers=%0d v=%b want 0 0", xfers, bus.oVALID);
    end
  endtask

  task automatic test_latency;
    int base;
    base = xfers;
    for (int i = 0; i < 3; i++) begin
      drive(SEG_3, 1'b1, 1'b1);
      total++;
      if (bus.oVALID !== 1'b0) begin
        bad++;
        $display("FAIL latency_early sample=%0d got v=%b want 0", i + 1, bus.oVALID);
      end
    end
    drive(SEG_3, 1'b1, 1'b1);
    total++;
    if (bus.oVALID !== 1'b1 || bus.oDIG !== 4'h3 || bus.oERR !== 1'b0) begin
      bad++;
      $display("FAIL latency_qualify got v=%b dig=%h e=%b want 1 3 0", bus.oVALID, bus.oDIG, bus.oERR);
    end
    for (int i = 0; i < 8; i++) drive(SEG_3, 1'b1, 1'b1);
    total++;
    if (xfers - base !== 1 || xferDig !== 4'h3 || bus.oVALID !== 1'b0) begin
      bad++;
      $display("FAIL latency_once got xfers=%0d dig=%h v=%b want 1 3 0", xfers - base, xferDig, bus.oVALID);
    end
  endtask

  task automatic test_blank_repeat;
    int base;
    base = xfers;
    for (int i = 0; i < 4; i++) drive(SEG_8, 1'b1, 1'b1);
    drive(SEG_BLANK, 1'b1, 1'b1);
    total++;
    if (xfers - base !== 1 || xferDig !== 4'h8) begin
      bad++;
      $display("FAIL blank_first8 got xfers=%0d dig=%h want 1 8", xfers - base, xferDig);
    end
    for (int i = 0; i < 3; i++) drive(SEG_BLANK, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(SEG_2, 1'b1, 1'b1);
    total++;
    if (xfers - base !== 1 || bus.oVALID !== 1'b0) begin
      bad++;
      $display("FAIL blank_glitch_silent got xfers=%0d v=%b want 1 0", xfers - base, bus.oVALID);
    end
    for (int i = 0; i < 3; i++) drive(SEG_8, 1'b1, 1'b1);
    total++;
    if (bus.oVALID !== 1'b0) begin
      bad++;
      $display("FAIL blank_restart_early got v=%b want 0", bus.oVALID);
    end
    drive(SEG_8, 1'b1, 1'b1);
    drive(SEG_8, 1'b1, 1'b1);
    total++;
    if (xfers - base !== 2 || xferDig !== 4'h8) begin
      bad++;
      $display("FAIL blank_second8 got xfers=%0d dig=%h want 2 8", xfers - base, xferDig);
    end
  endtask

  task automatic test_illegal;
    int base;
    base = xfers;
    for (int i = 0; i < 4; i++) drive(SEG_BAD, 1'b1, 1'b1);
    total++;
    if (bus.oVALID !== 1'b1 || bus.oERR !== 1'b1 || bus.oDIG !== 4'h0) begin
      bad++;
      $display("FAIL illegal_flag got v=%b e=%b dig=%h want 1 1 0", bus.oVALID, bus.oERR, bus.oDIG);
    end
    for (int i = 0; i < 3; i++) drive(SEG_BAD, 1'b1, 1'b1);
    total++;
    if (xfers - base !== 1 || xferErr !== 1'b1) begin
      bad++;
      $display("FAIL illegal_once got xfers=%0d e=%b want 1 1", xfers - base, xferErr);
    end
  endtask

  task automatic test_backpressure;
    int base;
    base = xfers;
    for (int i = 0; i < 4; i++) drive(SEG_5, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(SEG_6, 1'b1, 1'b0);
    total++;
    if (bus.oDROP !== 1'b0 || bus.oDIG !== 4'h5 || bus.oVALID !== 1'b1) begin
      bad++;
      $display("FAIL bp_hold got drop=%b dig=%h v=%b want 0 5 1", bus.oDROP, bus.oDIG, bus.oVALID);
    end
    drive(SEG_6, 1'b1, 1'b0);
    total++;
    if (bus.oDROP !== 1'b1 || bus.oDIG !== 4'h5) begin
      bad++;
      $display("FAIL bp_drop_pulse got drop=%b dig=%h want 1 5", bus.oDROP, bus.oDIG);
    end
    drive(SEG_6, 1'b1, 1'b0);
    total++;
    if (bus.oDROP !== 1'b0) begin
      bad++;
      $display("FAIL bp_drop_width got drop=%b want 0", bus.oDROP);
    end
    drive(SEG_6, 1'b1, 1'b1);
    drive(SEG_6, 1'b1, 1'b1);
    drive(SEG_6, 1'b1, 1'b1);
    total++;
    if (xfers - base !== 1 || xferDig !== 4'h5 || bus.oVALID !== 1'b0) begin
      bad++;
      $display("FAIL bp_only5 got xfers=%0d dig=%h v=%b want 1 5 0", xfers - base, xferDig, bus.oVALID);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    base = xfers;
    for (int i = 0; i < 4; i++) drive(SEG_9, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive(SEG_7, 1'b1, 1'b0);
    drive(SEG_7, 1'b1, 1'b1);
    total++;
    if (bus.oVALID !== 1'b1 || bus.oDIG !== 4'h7 || bus.oDROP !== 1'b0) begin
      bad++;
      $display("FAIL b2b_reload got v=%b dig=%h drop=%b want 1 7 0", bus.oVALID, bus.oDIG, bus.oDROP);
    end
    total++;
    if (xfers - base !== 1 || xferDig !== 4'h9) begin
      bad++;
      $display("FAIL b2b_first got xfers=%0d dig=%h want 1 9", xfers - base, xferDig);
    end
    drive(SEG_7, 1'b1, 1'b1);
    total++;
    if (xfers - base !== 2 || xferDig !== 4'h7 || bus.oVALID !== 1'b0) begin
      bad++;
      $display("FAIL b2b_second got xfers=%0d dig=%h v=%b want 2 7 0", xfers - base, xferDig, bus.oVALID);
    end
  endtask

  task automatic test_enable_gaps;
    logic [6:0] enPat;
    enPat = 7'b1010101;
    for (int i = 0; i < 6; i++) begin
      drive(SEG_A, enPat[i], 1'b1);
      total++;
      if (bus.oVALID !== 1'b0) begin
        bad++;
        $display("FAIL gaps_early edge=%0d got v=%b want 0", i + 1, bus.oVALID);
      end
    end
    drive(SEG_A, enPat[6], 1'b1);
    total++;
    if (bus.oVALID !== 1'b1 || bus.oDIG !== 4'hA) begin
      bad++;
      $display("FAIL gaps_edge7 got v=%b dig=%h want 1 a", bus.oVALID, bus.oDIG);
    end
    drive(SEG_A, 1'b0, 1'b1);
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) drive(SEG_E, 1'b1, 1'b0);
    total++;
    if (bus.oVALID !== 1'b1 || bus.oDIG !== 4'hE) begin
      bad++;
      $display("FAIL rst_pending got v=%b dig=%h want 1 e", bus.oVALID, bus.oDIG);
    end
    for (int i = 0; i < 3; i++) drive(SEG_C, 1'b1, 1'b0);
    rstN = 1'b0;
    drive(SEG_C, 1'b1, 1'b0);
    rstN = 1'b1;
    total++;
    if ({bus.oVALID, bus.oERR, bus.oDROP, bus.oDIG} !== 7'b0) begin
      bad++;
      $display("FAIL rst_mid_outputs got v=%b e=%b d=%b dig=%h want all 0",
               bus.oVALID, bus.oERR, bus.oDROP, bus.oDIG);
    end
    for (int i = 0; i < 3; i++) drive(SEG_C, 1'b1, 1'b0);
    total++;
    if (bus.oVALID !== 1'b0) begin
      bad++;
      $display("FAIL rst_fresh_early got v=%b want 0", bus.oVALID);
    end
    drive(SEG_C, 1'b1, 1'b0);
    total++;
    if (bus.oVALID !== 1'b1 || bus.oDIG !== 4'hC) begin
      bad++;
      $display("FAIL rst_fresh_qualify got v=%b dig=%h want 1 c", bus.oVALID, bus.oDIG);
    end
  endtask

  initial begin
    rstN        = 1'b0;
    bus.iSEG    = SEG_BLANK;
    bus.iSEG_EN = 1'b0;
    bus.iREADY  = 1'b0;
    test_reset();
    test_latency();
    test_blank_repeat();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_enable_gaps();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
